// File: rtl/bwt_pkg.sv
// Types and constants shared by the BWT rotation feeder and the merge-sort stage.
package bwt_pkg;

    localparam int BYTE_W    = 8;
    localparam int ROW_BYTES = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT,
        DONE
    } bwt_state_e;

    typedef logic [ROW_BYTES-1:0][BYTE_W-1:0] row_t;

endpackage

// File: rtl/bwt_byte_rotbuf.sv
// COLUMN-byte block buffer with indexed byte load and rotate-left-by-one.
module bwt_byte_rotbuf
    import bwt_pkg::*;
#(
    parameter int COLUMN = 3,
    parameter int IDX_W  = $clog2(COLUMN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_en_i,
    input  logic [IDX_W-1:0]             ld_idx_i,
    input  logic [BYTE_W-1:0]            ld_byte_i,
    input  logic                         rot_en_i,
    output logic [COLUMN-1:0][BYTE_W-1:0] data_o
);

    logic [COLUMN-1:0][BYTE_W-1:0] buf_q;
    logic [COLUMN-1:0][BYTE_W-1:0] buf_d;

    always_comb begin
        buf_d = buf_q;
        // New byte k takes old byte k+1; byte 0 wraps to the top.
        if (rot_en_i) begin
            buf_d = {buf_q[0], buf_q[COLUMN-1:1]};
        end else if (ld_en_i) begin
            buf_d[ld_idx_i] = ld_byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign data_o = buf_q;

endmodule

// File: rtl/bwt_rotation_gen.sv
// Loads one COLUMN-byte block and emits all cyclic rotations to the sort FIFOs.
// Define BWT_ROTGEN_SPLIT_EN to alternate rows between FIFO 0 and FIFO 1.
module bwt_rotation_gen
    import bwt_pkg::*;
#(
    parameter int COLUMN = 3,
    parameter int IDX_W  = $clog2(COLUMN)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BYTE_W-1:0]             in_byte,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    fifo_full,
    output logic [COLUMN-1:0][BYTE_W-1:0] rot_row,
    output logic [IDX_W-1:0]              rot_idx,
    output logic [1:0]                    wr_fifo,
    output logic                          busy,
    output logic                          done
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(COLUMN - 1);

    bwt_state_e state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] rot_q, rot_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [COLUMN-1:0][BYTE_W-1:0] row_q, row_d;
    logic [1:0] wr_q, wr_d;
    logic done_q, done_d;

    logic ld_en;
    logic rot_en;
    logic tgt;
    logic [COLUMN-1:0][BYTE_W-1:0] buf_data;

`ifdef BWT_ROTGEN_SPLIT_EN
    assign tgt = rot_q[0];
`else
    logic unused_full1;
    assign tgt          = 1'b0;
    assign unused_full1 = fifo_full[1];
`endif

    bwt_byte_rotbuf #(
        .COLUMN(COLUMN),
        .IDX_W (IDX_W)
    ) u_rotbuf (
        .clk      (clk),
        .rst      (rst),
        .ld_en_i  (ld_en),
        .ld_idx_i (cnt_q),
        .ld_byte_i(in_byte),
        .rot_en_i (rot_en),
        .data_o   (buf_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rot_d   = rot_q;
        idx_d   = idx_q;
        row_d   = row_q;
        wr_d    = 2'b00;
        done_d  = 1'b0;
        ld_en   = 1'b0;
        rot_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    ld_en = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = EMIT;
                        cnt_d   = '0;
                        rot_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                // The buffer only advances on a write, so a stall holds the row.
                if (!fifo_full[tgt]) begin
                    row_d     = buf_data;
                    idx_d     = rot_q;
                    wr_d[tgt] = 1'b1;
                    rot_en    = 1'b1;
                    if (rot_q == LAST) begin
                        state_d = DONE;
                        rot_d   = '0;
                    end else begin
                        rot_d = rot_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rot_q   <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            wr_q    <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rot_q   <= rot_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
        end
    end

    assign rot_row  = row_q;
    assign rot_idx  = idx_q;
    assign wr_fifo  = wr_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);
    assign in_ready = (state_q == LOAD);

endmodule

// File: tb/tb_bwt_rotation_gen.sv
// Randomized bench for bwt_rotation_gen against a rotation/FIFO reference model.
module tb_bwt_rotation_gen;

    localparam int C  = 3;
    localparam int IW = $clog2(C);

    typedef logic [C-1:0][7:0] row_t;
    typedef struct {
        int   f;
        row_t row;
        int   idx;
        int   cyc;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    fifo_full;
    row_t          rot_row;
    logic [IW-1:0] rot_idx;
    logic [1:0]    wr_fifo;
    logic          busy;
    logic          done;

    int   vecs     = 0;
    int   errs     = 0;
    int   cyc      = 0;
    int   hold_bad = 0;
    row_t prev_row = '0;
    wr_t  wlog[$];
    int   dlog[$];

    bwt_rotation_gen #(.COLUMN(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fifo_full(fifo_full),
        .rot_row  (rot_row),
        .rot_idx  (rot_idx),
        .wr_fifo  (wr_fifo),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_fifo != 2'b00) begin
            wlog.push_back('{f: (wr_fifo == 2'b01) ? 0 : (wr_fifo == 2'b10) ? 1 : 3,
                             row: rot_row, idx: int'(rot_idx), cyc: cyc});
        end else if (rot_row !== prev_row && rot_row !== '0) begin
            hold_bad <= hold_bad + 1;
        end
        if (done === 1'b1) dlog.push_back(cyc);
        prev_row <= rot_row;
    end

    function automatic row_t exp_row(row_t blk, int i);
        row_t r;
        for (int k = 0; k < C; k++) r[k] = blk[(i + k) % C];
        return r;
    endfunction

    function automatic int exp_fifo(int i);
`ifdef BWT_ROTGEN_SPLIT_EN
        return i % 2;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_block(input row_t blk, input int gap_pct);
        for (int i = 0; i < C; i++) begin
            for (int g = 0; g < 6 && $urandom_range(0, 99) < gap_pct; g++) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_byte  = blk[i];
            tick();
        end
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    // Drives fifo_full per decision cycle and predicts when each row lands.
    task automatic run_emit(input int pct, input bit poke, output int wc[C]);
        int r = 0;
        int guard = 0;
        while (r < C && guard < 400) begin
            fifo_full[0] = ($urandom_range(0, 99) < pct);
            fifo_full[1] = ($urandom_range(0, 99) < pct);
            start = poke && (r == 1);
            if (!fifo_full[exp_fifo(r)]) begin
                wc[r] = cyc + 1;
                r++;
            end
            tick();
            guard++;
        end
        start     = 1'b0;
        fifo_full = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vecs++;
        if ({rot_row, rot_idx, wr_fifo, done, in_ready, busy} !== '0) begin
            errs++;
            $display("FAIL reset_hold got row=%h idx=%0d wr=%b done=%b rdy=%b busy=%b need all 0",
                     rot_row, rot_idx, wr_fifo, done, in_ready, busy);
        end
        rst = 1'b0;
        tick();
        vecs++;
        if ({rot_row, rot_idx, wr_fifo, done, in_ready, busy} !== '0) begin
            errs++;
            $display("FAIL reset_release got row=%h wr=%b busy=%b need all 0",
                     rot_row, wr_fifo, busy);
        end
    endtask

    task automatic test_basic();
        row_t blk;
        int c0;
        blk[0] = 8'h42;
        blk[1] = 8'h41;
        blk[2] = 8'h4E;
        wlog.delete();
        dlog.delete();
        pulse_start();
        vecs++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL basic_load_state got rdy=%b busy=%b need 1 1", in_ready, busy);
        end
        load_block(blk, 0);
        c0 = cyc;
        repeat (C + 3) tick();
        vecs++;
        if (wlog.size() != C) begin
            errs++;
            $display("FAIL basic_count got %0d writes need %0d", wlog.size(), C);
        end
        for (int i = 0; i < C && i < wlog.size(); i++) begin
            vecs++;
            if (wlog[i].row !== exp_row(blk, i) || wlog[i].idx != i ||
                wlog[i].f != exp_fifo(i) || wlog[i].cyc != c0 + 1 + i) begin
                errs++;
                $display("FAIL basic_row%0d got row=%h idx=%0d fifo=%0d cyc=%0d need row=%h idx=%0d fifo=%0d cyc=%0d",
                         i, wlog[i].row, wlog[i].idx, wlog[i].f, wlog[i].cyc,
                         exp_row(blk, i), i, exp_fifo(i), c0 + 1 + i);
            end
        end
        vecs++;
        if (dlog.size() != 1 || dlog[0] != c0 + C + 1) begin
            errs++;
            $display("FAIL basic_done got %0d pulses first at %0d need 1 at %0d",
                     dlog.size(), (dlog.size() > 0) ? dlog[0] : -1, c0 + C + 1);
        end
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL basic_idle got busy=%b need 0", busy);
        end
    endtask

    task automatic test_backpressure();
        row_t blk;
        int c0;
        int need[C];
        blk = row_t'($urandom);
        wlog.delete();
        dlog.delete();
        pulse_start();
        load_block(blk, 0);
        c0 = cyc;
        tick();
        fifo_full[exp_fifo(1)] = 1'b1;
        repeat (4) tick();
        fifo_full = 2'b00;
        repeat (5) tick();
        need[0] = c0 + 1;
        need[1] = c0 + 6;
        need[2] = c0 + 7;
        vecs++;
        if (wlog.size() != C) begin
            errs++;
            $display("FAIL bp_count got %0d writes need %0d", wlog.size(), C);
        end
        for (int i = 0; i < C && i < wlog.size(); i++) begin
            vecs++;
            if (wlog[i].row !== exp_row(blk, i) || wlog[i].idx != i ||
                wlog[i].f != exp_fifo(i) || wlog[i].cyc != need[i]) begin
                errs++;
                $display("FAIL bp_row%0d got row=%h idx=%0d cyc=%0d need row=%h idx=%0d cyc=%0d",
                         i, wlog[i].row, wlog[i].idx, wlog[i].cyc,
                         exp_row(blk, i), i, need[i]);
            end
        end
        vecs++;
        if (dlog.size() != 1 || dlog[0] != c0 + 8) begin
            errs++;
            $display("FAIL bp_done got %0d pulses need 1 at %0d", dlog.size(), c0 + 8);
        end
    endtask

    task automatic test_gaps();
        row_t blk;
        bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int n = 0;
        int wc[C];
        blk = row_t'($urandom);
        wlog.delete();
        dlog.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            vecs++;
            if (in_ready !== 1'b1) begin
                errs++;
                $display("FAIL gaps_ready step%0d got %b need 1", i, in_ready);
            end
            in_valid = pat[i];
            in_byte  = pat[i] ? blk[n] : 8'hEE;
            if (pat[i]) n++;
            tick();
        end
        in_valid = 1'b0;
        vecs++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL gaps_emit got rdy=%b busy=%b need 0 1", in_ready, busy);
        end
        run_emit(0, 1'b0, wc);
        vecs++;
        if (wlog.size() != C) begin
            errs++;
            $display("FAIL gaps_count got %0d need %0d", wlog.size(), C);
        end
        for (int i = 0; i < C && i < wlog.size(); i++) begin
            vecs++;
            if (wlog[i].row !== exp_row(blk, i) || wlog[i].idx != i || wlog[i].f != exp_fifo(i)) begin
                errs++;
                $display("FAIL gaps_row%0d got row=%h idx=%0d need row=%h idx=%0d",
                         i, wlog[i].row, wlog[i].idx, exp_row(blk, i), i);
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        row_t blk;
        int wc[C];
        blk = row_t'($urandom);
        wlog.delete();
        dlog.delete();
        pulse_start();
        load_block(blk, 0);
        tick();
        rst = 1'b1;
        tick();
        vecs++;
        if ({rot_row, rot_idx, wr_fifo, done, in_ready, busy} !== '0) begin
            errs++;
            $display("FAIL rst_mid_out got row=%h idx=%0d wr=%b done=%b busy=%b need all 0",
                     rot_row, rot_idx, wr_fifo, done, busy);
        end
        rst = 1'b0;
        repeat (6) tick();
        vecs++;
        if (wlog.size() != 1 || dlog.size() != 0) begin
            errs++;
            $display("FAIL rst_mid_quiet got %0d writes %0d done need 1 0",
                     wlog.size(), dlog.size());
        end
        blk[0] = 8'h01;
        blk[1] = 8'h02;
        blk[2] = 8'h03;
        wlog.delete();
        pulse_start();
        load_block(blk, 0);
        run_emit(0, 1'b0, wc);
        vecs++;
        if (wlog.size() != C || dlog.size() != 1) begin
            errs++;
            $display("FAIL rst_mid_new got %0d writes %0d done need %0d 1",
                     wlog.size(), dlog.size(), C);
        end
        for (int i = 0; i < C && i < wlog.size(); i++) begin
            vecs++;
            if (wlog[i].row !== exp_row(blk, i) || wlog[i].idx != i) begin
                errs++;
                $display("FAIL rst_mid_row%0d got row=%h idx=%0d need row=%h idx=%0d",
                         i, wlog[i].row, wlog[i].idx, exp_row(blk, i), i);
            end
        end
    endtask

    task automatic test_start_busy();
        row_t blk;
        int wc[C];
        blk = row_t'($urandom);
        wlog.delete();
        dlog.delete();
        pulse_start();
        in_valid = 1'b1;
        in_byte  = blk[0];
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < C; i++) begin
            in_byte = blk[i];
            tick();
        end
        in_valid = 1'b0;
        run_emit(0, 1'b1, wc);
        vecs++;
        if (wlog.size() != C || dlog.size() != 1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL start_busy got %0d writes %0d done busy=%b need %0d 1 0",
                     wlog.size(), dlog.size(), busy, C);
        end
        for (int i = 0; i < C && i < wlog.size(); i++) begin
            vecs++;
            if (wlog[i].row !== exp_row(blk, i) || wlog[i].idx != i) begin
                errs++;
                $display("FAIL start_busy_row%0d got row=%h need %h", i, wlog[i].row, exp_row(blk, i));
            end
        end
    endtask

    task automatic test_random();
        row_t blk;
        int wc[C];
        for (int b = 0; b < 8; b++) begin
            blk = row_t'($urandom);
            wlog.delete();
            dlog.delete();
            pulse_start();
            load_block(blk, 40);
            run_emit(45, 1'b0, wc);
            vecs++;
            if (wlog.size() != C) begin
                errs++;
                $display("FAIL rand%0d_count got %0d need %0d", b, wlog.size(), C);
            end
            for (int i = 0; i < C && i < wlog.size(); i++) begin
                vecs++;
                if (wlog[i].row !== exp_row(blk, i) || wlog[i].idx != i ||
                    wlog[i].f != exp_fifo(i) || wlog[i].cyc != wc[i]) begin
                    errs++;
                    $display("FAIL rand%0d_row%0d got row=%h idx=%0d fifo=%0d cyc=%0d need row=%h idx=%0d fifo=%0d cyc=%0d",
                             b, i, wlog[i].row, wlog[i].idx, wlog[i].f, wlog[i].cyc,
                             exp_row(blk, i), i, exp_fifo(i), wc[i]);
                end
            end
            vecs++;
            if (dlog.size() != 1 || dlog[0] != wc[C-1] + 1) begin
                errs++;
                $display("FAIL rand%0d_done got %0d pulses need 1 at %0d", b, dlog.size(), wc[C-1] + 1);
            end
        end
    endtask

    task automatic test_hold();
        vecs++;
        if (hold_bad != 0) begin
            errs++;
            $display("FAIL row_hold got %0d unstrobed row changes need 0", hold_bad);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        fifo_full = 2'b00;
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_reset_mid_emit();
        test_start_busy();
        test_random();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout need completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bwt_rotation_gen.md
Name: bwt_rotation_gen

Overview:
Upstream feeder of the BWT merge-sort stage. It captures one input block of COLUMN bytes from a byte stream, then emits all COLUMN cyclic rotations as packed rows into the two input FIFOs of the sort stage. Rows are distributed alternately between the two FIFOs so that the sort stage can merge them pairwise. Each emitted row carries its rotation index so that later stages can locate the BWT primary index.

Parameters:
COLUMN, 3, block length in bytes; also the row width in bytes; must be >= 2.
IDX_W, $clog2(COLUMN), width of the rotation index and internal counters.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle pulse; begins loading a block; honoured only in IDLE
in_byte  input  8  input stream byte
in_valid  input  1  in_byte is valid
in_ready  output  1  block accepts in_byte; high only in LOAD
fifo_full  input  [1:0]  full flags of sort-stage FIFO 1 and FIFO 0
rot_row  output  [COLUMN-1:0][7:0]  registered rotation row
rot_idx  output  IDX_W  registered rotation index of rot_row
wr_fifo  output  [1:0]  registered one-hot write strobes for FIFO 1 and FIFO 0
busy  output  1  high when the FSM is not in IDLE
done  output  1  one-cycle pulse after the last row is written

Behaviour:
- Reset values:
  - rot_row=0, rot_idx=0, wr_fifo=2'b00, done=0, in_ready=0, busy=0.
  - State goes to IDLE; the byte buffer and counters are cleared.
- A reset during LOAD or EMIT aborts the block. Partial data is discarded and no further writes occur.
- States:
  - IDLE: start -> LOAD, with cnt=0. Any other input is ignored.
  - LOAD:
    - in_ready=1.
    - On in_valid, in_byte is stored to buf[cnt] and cnt increments. The first byte received lands at index 0.
    - After the byte with cnt==COLUMN-1 is accepted -> EMIT, with rot=0.
    - in_valid low stalls without timeout.
  - EMIT:
    - Target FIFO is t = rot[0] (even rotations go to FIFO 0, odd to FIFO 1).
    - If fifo_full[t]==0:
      - register rot_row<=buf, rot_idx<=rot, and set wr_fifo[t]<=1 for exactly one cycle;
      - rotate buf left by one byte: buf[k]<=buf[k+1], buf[COLUMN-1]<=buf[0];
      - rot increments.
    - If fifo_full[t]==1: wr_fifo<=0, and buf and rot are held (stall).
    - After the write with rot==COLUMN-1 -> DONE.
  - DONE: done=1 for one cycle, wr_fifo=0 -> IDLE.
- Row content: rotation i satisfies rot_row[k] = block[(i+k) mod COLUMN].
- Throughput and latency:
  - Throughput is at most one write per cycle.
  - Without backpressure, EMIT takes exactly COLUMN cycles.
  - Write strobe and row appear together, one cycle after the decision cycle.
  - fifo_full is sampled in the decision cycle, so the sort-stage FIFOs assert full with at least one entry of margin.
- wr_fifo is never 2'b11. rot_row holds its value when wr_fifo==0.
- start is ignored while busy; no queuing.
- Counters never wrap past COLUMN-1; comparisons use IDX_W bits.

Optional Feature:
Macro BWT_ROTGEN_SPLIT_EN.
- Defined: rows are distributed alternately to FIFO 0 and FIFO 1 as described above.
- Undefined: every row targets FIFO 0. wr_fifo[1] is tied to 0 and fifo_full[1] is ignored. Timing is otherwise identical.

Decomposition:
- Shared package bwt_pkg holds:
  - the state enum typedef (IDLE, LOAD, EMIT, DONE);
  - the BYTE_W=8 constant;
  - the row typedef, a COLUMN x byte packed array.
- The package is shared with the sort stage.
- One sub-module, bwt_byte_rotbuf, is natural: a COLUMN-byte buffer with indexed load and rotate-left-by-one controls. The FSM and counters stay in the top module.

Test Plan:
- Basic, COLUMN=3: start, then bytes 0x42,0x41,0x4E with no backpressure.
  - Expect FIFO 0 {42,41,4E} idx0, FIFO 1 {41,4E,42} idx1, FIFO 0 {4E,42,41} idx2 (listed as row[0],row[1],row[2]).
  - Expect them on consecutive cycles, then a done pulse one cycle after the last write.
- Backpressure: same block with fifo_full[1]=1 for 4 cycles during rot=1.
  - Expect wr_fifo=0 throughout the stall and buf held.
  - Expect row idx1 written on the cycle after fifo_full[1] drops; row order unchanged.
- Input gaps: in_valid toggling 1,0,0,1,0,1.
  - Expect exactly 3 bytes accepted, in_ready high during gaps, rows identical to the basic case.
- Reset mid-EMIT: assert rst after the idx0 write.
  - Expect all outputs 0 the next cycle and no further writes.
  - A new block of 0x01,0x02,0x03 then yields {01,02,03},{02,03,01},{03,01,02}.
- start while busy: pulse start during LOAD and during EMIT → ignored; exactly COLUMN writes and one done.
- Macro undefined: basic stimulus → all three rows on wr_fifo[0]; wr_fifo[1] never asserted.
